// File: rtl/jtag_tap_port.sv
// JTAG TAP front end: synchronises tck/tms/tdi into clk, runs the 1149.1 TAP
// machine, and hands DR/IR contents to the downstream memory-bus controller.
module jtag_tap_port #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned UPD_CYCLES  = 4,
    parameter logic [7:0]  CAPIR_VAL   = 8'h01
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    input  logic        wrData,
    output logic        doUpdate,
    output logic [7:0]  instrLine,
    inout  wire  [15:0] dataLine
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = $clog2(UPD_CYCLES + 1);
    localparam logic [IW-1:0] INSTR_READ = 8'h02;

    typedef enum logic [3:0] {
        S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAUSE_DR, S_EX2_DR,
        S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAUSE_IR, S_EX2_IR, S_UPD_IR
    } tap_state_t;

    logic [SYNC_STAGES-1:0] r_tck_sync;
    logic [SYNC_STAGES-1:0] r_tms_sync;
    logic [SYNC_STAGES-1:0] r_tdi_sync;
    logic                   r_tck_hist;
    tap_state_t             r_state;
    tap_state_t             w_next;
    logic [IW-1:0]          r_ir;
    logic [IW-1:0]          r_instr;
    logic [DW-1:0]          r_dr;
    logic                   r_tdo;
    logic                   r_do_update;
    logic [CW-1:0]          r_upd_cnt;
    logic                   w_tck_s;
    logic                   w_tms_s;
    logic                   w_tdi_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_drive;

    assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
    assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
    assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];
    assign w_rise  = w_tck_s & ~r_tck_hist;
    assign w_fall  = ~w_tck_s & r_tck_hist;

    // Synchronisers plus tck history for edge strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_hist <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck};
            r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms};
            r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
            r_tck_hist <= w_tck_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_TLR;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_rise) begin
            unique case (r_state)
                S_TLR:      w_next = w_tms_s ? S_TLR      : S_RTI;
                S_RTI:      w_next = w_tms_s ? S_SEL_DR   : S_RTI;
                S_SEL_DR:   w_next = w_tms_s ? S_SEL_IR   : S_CAP_DR;
                S_CAP_DR:   w_next = w_tms_s ? S_EX1_DR   : S_SH_DR;
                S_SH_DR:    w_next = w_tms_s ? S_EX1_DR   : S_SH_DR;
                S_EX1_DR:   w_next = w_tms_s ? S_UPD_DR   : S_PAUSE_DR;
                S_PAUSE_DR: w_next = w_tms_s ? S_EX2_DR   : S_PAUSE_DR;
                S_EX2_DR:   w_next = w_tms_s ? S_UPD_DR   : S_SH_DR;
                S_UPD_DR:   w_next = w_tms_s ? S_SEL_DR   : S_RTI;
                S_SEL_IR:   w_next = w_tms_s ? S_TLR      : S_CAP_IR;
                S_CAP_IR:   w_next = w_tms_s ? S_EX1_IR   : S_SH_IR;
                S_SH_IR:    w_next = w_tms_s ? S_EX1_IR   : S_SH_IR;
                S_EX1_IR:   w_next = w_tms_s ? S_UPD_IR   : S_PAUSE_IR;
                S_PAUSE_IR: w_next = w_tms_s ? S_EX2_IR   : S_PAUSE_IR;
                S_EX2_IR:   w_next = w_tms_s ? S_UPD_IR   : S_SH_IR;
                S_UPD_IR:   w_next = w_tms_s ? S_SEL_DR   : S_RTI;
                default:    w_next = S_TLR;
            endcase
        end
    end

    // IR/DR shifting and latched instruction; a shift beats a wrData load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ir    <= '0;
            r_dr    <= '0;
            r_instr <= '0;
        end else begin
            if (w_rise && r_state == S_CAP_IR)     r_ir <= CAPIR_VAL;
            else if (w_rise && r_state == S_SH_IR) r_ir <= {w_tdi_s, r_ir[IW-1:1]};

            if (w_rise && r_state == S_SH_DR)      r_dr <= {w_tdi_s, r_dr[DW-1:1]};
            else if (wrData && r_do_update)        r_dr <= dataLine;

            if (w_rise && w_next == S_TLR)         r_instr <= '0;
            else if (w_rise && w_next == S_UPD_IR) r_instr <= r_ir;
        end
    end

    // Update window: any rise closes it, entering Update-DR (re)opens it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_do_update <= 1'b0;
            r_upd_cnt   <= '0;
        end else if (w_rise) begin
            r_do_update <= (w_next == S_UPD_DR);
            r_upd_cnt   <= (w_next == S_UPD_DR) ? CW'(UPD_CYCLES) : '0;
        end else if (r_upd_cnt != '0) begin
            r_do_update <= (r_upd_cnt > CW'(1));
            r_upd_cnt   <= r_upd_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tdo <= 1'b0;
        end else if (w_fall) begin
            if (r_state == S_SH_IR)      r_tdo <= r_ir[0];
            else if (r_state == S_SH_DR) r_tdo <= r_dr[0];
            else                         r_tdo <= 1'b0;
        end
    end

    // During a read the memory owns dataLine, so the DUT stays off it
    assign w_drive   = r_do_update & ~wrData & (r_instr != INSTR_READ);
    assign dataLine  = w_drive ? r_dr : 'z;
    assign tdo       = r_tdo;
    assign doUpdate  = r_do_update;
    assign instrLine = r_instr;

endmodule

// File: tb/tb_jtag_tap_port.sv
// Bench for jtag_tap_port: table vectors, directed corner sequences and a
// random tms/tdi stream checked against a table-driven 1149.1 model.
module tb_jtag_tap_port;

    localparam int PH = 10;
    localparam int UPD = 4;

    logic        clk;
    logic        rstn;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        wrData;
    logic        doUpdate;
    logic [7:0]  instrLine;
    wire  [15:0] dataLine;
    logic [15:0] tb_drv;
    logic        tb_rd_own;

    // bench owns the line whenever the DUT should not be driving it
    assign dataLine = (tb_rd_own || !doUpdate) ? tb_drv : 16'bz;

    jtag_tap_port #(.SYNC_STAGES(2), .UPD_CYCLES(UPD), .CAPIR_VAL(8'h01)) dut (
        .clk(clk), .rstn(rstn), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .wrData(wrData), .doUpdate(doUpdate), .instrLine(instrLine), .dataLine(dataLine)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // State numbering: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PauseDR,7 Ex2DR,
    // 8 UpdDR,9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PauseIR,14 Ex2IR,15 UpdIR
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_state;
    logic [7:0]  m_ir;
    logic [7:0]  m_instr;
    logic [15:0] m_dr;
    logic        m_tdo;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit         tms;
        bit         tdi;
        bit         e_tdo;
        logic [7:0] e_instr;
        int         e_upd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset;
        m_state = 0; m_ir = '0; m_instr = '0; m_dr = '0; m_tdo = 1'b0;
    endtask

    task automatic m_rise(input bit t, input bit d, output int exp_upd);
        int ns;
        ns = t ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 10) m_ir = 8'h01;
        if (m_state == 11) m_ir = (m_ir >> 1) | (8'(d) << 7);
        if (m_state == 4)  m_dr = (m_dr >> 1) | (16'(d) << 15);
        if (ns == 0)  m_instr = 8'h00;
        if (ns == 15) m_instr = m_ir;
        m_state = ns;
        exp_upd = (ns == 8) ? UPD : 0;
    endtask

    task automatic m_fall;
        if (m_state == 11)     m_tdo = m_ir[0];
        else if (m_state == 4) m_tdo = m_dr[0];
        else                   m_tdo = 1'b0;
    endtask

    // tck-high phase: counts doUpdate cycles, checks dataLine ownership, optional wrData pulse
    task automatic high_phase(input bit do_wr, output int upd, output bit bad);
        logic [15:0] exp_d;
        bit pend;
        upd = 0; bad = 1'b0; pend = 1'b0;
        for (int i = 0; i < PH; i++) begin
            tick;
            exp_d = (doUpdate && m_instr != 8'h02) ? m_dr : tb_drv;
            if (dataLine !== exp_d) bad = 1'b1;
            if (pend) begin
                wrData = 1'b0; tb_drv = 16'h0000; m_dr = 16'hBEEF; pend = 1'b0;
            end
            if (doUpdate) begin
                upd++;
                if (do_wr && upd == 3) begin
                    tb_drv = 16'hBEEF; wrData = 1'b1; pend = 1'b1;
                end
            end
        end
    endtask

    task automatic tck_cycle(input bit t, input bit d, input bit do_wr,
                             output bit o_tdo, output int o_upd);
        int exp_upd;
        bit bad;
        tms = t; tdi = d;
        tick; tick;
        tck = 1'b1;
        m_rise(t, d, exp_upd);
        tb_rd_own = (m_instr == 8'h02);
        high_phase(do_wr, o_upd, bad);
        chk("upd_len", o_upd, exp_upd);
        chk("dl_owner", bad, 0);
        tck = 1'b0;
        repeat (PH) tick;
        m_fall;
        chk("tdo", tdo, m_tdo);
        chk("instr", instrLine, m_instr);
        o_tdo = tdo;
    endtask

    task automatic step(input bit t, input bit d);
        bit o; int u;
        tck_cycle(t, d, 1'b0, o, u);
    endtask

    task automatic scan_ir(input logic [7:0] v);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int k = 0; k < 8; k++) step(k == 7, v[k]);
        step(1, 0); step(0, 0);
    endtask

    // RTI -> ... -> Ex1DR, returning the 16 bits shifted out
    task automatic scan_dr_shift(input logic [15:0] v, output logic [15:0] out);
        bit o; int u;
        step(1, 0); step(0, 0);
        tck_cycle(1'b0, 1'b0, 1'b0, o, u);
        out[0] = o;
        for (int k = 0; k < 16; k++) begin
            tck_cycle(k == 15, v[k], 1'b0, o, u);
            if (k < 15) out[k+1] = o;
        end
    endtask

    task automatic finish_upd(input bit do_wr);
        bit o; int u;
        tck_cycle(1'b1, 1'b0, do_wr, o, u);
        step(0, 0);
    endtask

    // Ex1DR: rise into UpdDR, then a too-short tck low phase with tms=1
    task automatic short_update;
        int e; int upd; bit bad;
        tms = 1'b1; tdi = 1'b0;
        tick; tick;
        tck = 1'b1; m_rise(1'b1, 1'b0, e);
        tick;
        tck = 1'b0; m_fall;
        tick;
        tck = 1'b1; m_rise(1'b1, 1'b0, e);
        tb_rd_own = (m_instr == 8'h02);
        high_phase(1'b0, upd, bad);
        chk("short_upd_len", upd, 2);
        chk("short_dl_owner", bad, 0);
        tck = 1'b0;
        repeat (PH) tick;
        m_fall;
        chk("short_tdo", tdo, m_tdo);
        chk("short_instr", instrLine, m_instr);
    endtask

    function automatic void add(bit t, bit d, bit et, logic [7:0] ei, int eu);
        vec_t v;
        v.tms = t; v.tdi = d; v.e_tdo = et; v.e_instr = ei; v.e_upd = eu;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0]  cap;
        logic [7:0]  irv;
        logic [15:0] dv;
        logic [15:0] out;
        bit o; int u;

        rstn = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0; wrData = 1'b0;
        tb_drv = 16'h0000; tb_rd_own = 1'b0;
        m_reset;
        repeat (4) tick;
        chk("rst_tdo", tdo, 0);
        chk("rst_instr", instrLine, 8'h00);
        chk("rst_doupd", doUpdate, 0);
        chk("rst_dl", dataLine, 16'h0000);
        rstn = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) step(1, 0);

        // IR scan of 0x01 then DR scan of 0x1234 with instr 0x01
        cap = 8'h01; irv = 8'h01; dv = 16'h1234;
        add(0, 0, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 0); add(0, 0, cap[0], 8'h00, 0);
        for (int k = 0; k < 8; k++) add(k == 7, irv[k], (k < 7) ? cap[k+1] : 1'b0, 8'h00, 0);
        add(1, 0, 0, 8'h01, 0); add(0, 0, 0, 8'h01, 0);
        add(1, 0, 0, 8'h01, 0); add(0, 0, 0, 8'h01, 0); add(0, 0, 0, 8'h01, 0);
        for (int k = 0; k < 16; k++) add(k == 15, dv[k], 0, 8'h01, 0);
        add(1, 0, 0, 8'h01, UPD); add(0, 0, 0, 8'h01, 0);
        foreach (tbl[i]) begin
            tck_cycle(tbl[i].tms, tbl[i].tdi, 1'b0, o, u);
            chk("tbl_tdo", o, tbl[i].e_tdo);
            chk("tbl_instr", instrLine, tbl[i].e_instr);
            chk("tbl_upd", u, tbl[i].e_upd);
        end

        // read: memory data loaded via wrData, then shifted back out
        scan_ir(8'h02);
        chk("instr_read", instrLine, 8'h02);
        scan_dr_shift(16'h1111, out);
        chk("dr_prev_out", out, 16'h1234);
        finish_upd(1'b1);
        scan_dr_shift(16'h0000, out);
        chk("rd_back_out", out, 16'hBEEF);
        finish_upd(1'b0);

        // short tck phase during the update window
        scan_ir(8'h03);
        scan_dr_shift(16'h5A5B, out);
        short_update;
        tck_cycle(1'b0, 1'b0, 1'b0, o, u);
        tck_cycle(1'b0, 1'b0, 1'b0, o, u);
        chk("post_short_tdo", o, 1);
        step(1, 0); step(0, 0); step(1, 0);
        tck_cycle(1'b1, 1'b0, 1'b0, o, u);
        chk("pause_upd", u, UPD);
        step(0, 0);

        // reset in the middle of a DR shift
        scan_dr_shift(16'hA5A5, out);
        finish_upd(1'b0);
        step(1, 0); step(0, 0);
        tck_cycle(1'b0, 1'b0, 1'b0, o, u);
        chk("pre_rst_tdo", o, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_tdo", tdo, 0);
        chk("mid_rst_instr", instrLine, 8'h00);
        chk("mid_rst_doupd", doUpdate, 0);
        m_reset;
        tb_rd_own = 1'b0;
        repeat (3) tick;
        rstn = 1'b1;
        tick;
        step(0, 0);
        scan_dr_shift(16'h0000, out);
        chk("post_rst_dr", out, 16'h0000);
        finish_upd(1'b0);

        for (int i = 0; i < 200; i++) begin
            tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, o, u);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
